// File: rtl/mux_n_serializer_if.sv
`timescale 1ns/1ps
// Handshake bundle for mux_n_serializer: parallel word in, serial bit stream out.
// slave = serializer view; master = the surrounding logic that feeds it and drains it.
// N is the select width, so a word is 2**N bits.
interface mux_n_serializer_if #(
  parameter int N = 3
);
  logic             s_valid;
  logic             s_ready;
  logic [2**N-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_data;
  logic             m_last;
  logic             busy;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/mux_n_serializer.sv
`timescale 1ns/1ps
// Purpose: parallel-to-serial front end driving a mux_n tree; one word in, 2**N bits out with last flag.
// Latency: word accepted at edge t shows its first bit with m_valid in the following cycle.
// Backpressure: m_ready low freezes cnt/m_data/m_last; s_ready only rises in IDLE or on the final bit handshake.
// Config: define MUX_N_SERIALIZER_MSB_FIRST_EN to send bit 2**N-1 first (default LSB first).

// Plain selector: out = in[sel].
module mux_n #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] in,
  input  logic [N-1:0]    sel,
  output logic            out
);
  assign out = in[sel];
endmodule

module mux_n_serializer #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_n_serializer_if.slave    bus
);
  localparam int W = 2**N;

`ifdef MUX_N_SERIALIZER_MSB_FIRST_EN
  localparam logic [N-1:0] C_START = {N{1'b1}};
  localparam logic [N-1:0] C_END   = '0;
`else
  localparam logic [N-1:0] C_START = '0;
  localparam logic [N-1:0] C_END   = {N{1'b1}};
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_word;
  logic [N-1:0]   r_cnt;

  logic           w_m_valid;
  logic           w_m_last;
  logic           w_m_hs;
  logic           w_s_ready;
  logic           w_load;
  logic           w_m_data;
  logic [N-1:0]   w_cnt_step;

  // Step toward the end position; only used while cnt != END so it never wraps.
`ifdef MUX_N_SERIALIZER_MSB_FIRST_EN
  assign w_cnt_step = r_cnt - N'(1);
`else
  assign w_cnt_step = r_cnt + N'(1);
`endif

  assign w_m_valid = (r_state == SEND);
  assign w_m_last  = w_m_valid & (r_cnt == C_END);
  assign w_m_hs    = w_m_valid & bus.m_ready;
  // Ready is held low during reset and opens combinationally on the final-bit handshake
  // so a waiting word follows without a bubble.
  assign w_s_ready = rst_n & ((r_state == IDLE) | (w_m_hs & w_m_last));
  assign w_load    = bus.s_valid & w_s_ready;

  mux_n #(.N(N)) u_mux (
    .in  (r_word),
    .sel (r_cnt),
    .out (w_m_data)
  );

  // FSM: load on accept, walk cnt per bit handshake, return to IDLE after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_cnt   <= C_START;
    end else if (w_load) begin
      r_word  <= bus.s_data;
      r_cnt   <= C_START;
      r_state <= SEND;
    end else if (w_m_hs) begin
      if (w_m_last) begin
        r_state <= IDLE;
        r_cnt   <= C_START;
      end else begin
        r_cnt   <= w_cnt_step;
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = w_m_data;
  assign bus.m_last  = w_m_last;
  assign bus.busy    = w_m_valid;
endmodule

// File: tb/tb_mux_n_serializer.sv
`timescale 1ns/1ps
// Directed bench for mux_n_serializer: instances with N=3, N=2 and N=1 share clock and reset.
// Inputs change on the falling edge; outputs are checked 1ns later.
// Expected bit order follows MUX_N_SERIALIZER_MSB_FIRST_EN as compiled.
module tb_mux_n_serializer;
`ifdef MUX_N_SERIALIZER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux_n_serializer_if #(.N(3)) if3 ();
  mux_n_serializer_if #(.N(2)) if2 ();
  mux_n_serializer_if #(.N(1)) if1 ();

  mux_n_serializer #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  mux_n_serializer #(.N(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mux_n_serializer #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word bit index carried by the i-th serial bit of a 2**n-bit word.
  function automatic int bidx(input int i, input int n);
    return MSB_FIRST ? ((1 << n) - 1 - i) : i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w8;
    logic [3:0] w4a;
    logic [3:0] w4b;
    logic [1:0] w2;
    logic       e;
    int         idx;
    int         cyc;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    if3.s_valid = 1'b0; if3.s_data = '0; if3.m_ready = 1'b1;
    if2.s_valid = 1'b0; if2.s_data = '0; if2.m_ready = 1'b1;
    if1.s_valid = 1'b0; if1.s_data = '0; if1.m_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", if3.s_ready, 0);
    chk("rst_m_valid", if3.m_valid, 0);
    chk("rst_m_last",  if3.m_last,  0);
    chk("rst_busy",    if3.busy,    0);
    chk("rst_m_data",  if3.m_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", if3.s_ready, 1);
    chk("rel_m_valid", if3.m_valid, 0);

    // N=3, 8'hA5, m_ready held high
    @(negedge clk);
    w8 = 8'hA5;
    if3.s_data = w8; if3.s_valid = 1'b1;
    #1;
    chk("a5_accept_s_ready", if3.s_ready, 1);
    @(negedge clk);
    if3.s_valid = 1'b0; if3.s_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = w8[bidx(i, 3)];
      chk($sformatf("a5_b%0d_valid", i), if3.m_valid, 1);
      chk($sformatf("a5_b%0d_data", i),  if3.m_data,  {31'd0, e});
      chk($sformatf("a5_b%0d_last", i),  if3.m_last,  (i == 7) ? 1 : 0);
      chk($sformatf("a5_b%0d_rdy", i),   if3.s_ready, (i == 7) ? 1 : 0);
      chk($sformatf("a5_b%0d_busy", i),  if3.busy,    1);
      @(negedge clk);
    end
    #1;
    chk("a5_end_busy",    if3.busy,    0);
    chk("a5_end_m_valid", if3.m_valid, 0);
    chk("a5_end_s_ready", if3.s_ready, 1);

    // N=2 back-to-back 4'h3 then 4'hC, s_valid held
    @(negedge clk);
    w4a = 4'h3; w4b = 4'hC;
    if2.s_data = w4a; if2.s_valid = 1'b1;
    @(negedge clk);
    if2.s_data = w4b;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = (i < 4) ? w4a[bidx(i, 2)] : w4b[bidx(i - 4, 2)];
      chk($sformatf("b2b_b%0d_valid", i), if2.m_valid, 1);
      chk($sformatf("b2b_b%0d_data", i),  if2.m_data,  {31'd0, e});
      chk($sformatf("b2b_b%0d_last", i),  if2.m_last,  (i % 4 == 3) ? 1 : 0);
      chk($sformatf("b2b_b%0d_rdy", i),   if2.s_ready, (i % 4 == 3) ? 1 : 0);
      @(negedge clk);
      if (i == 3) if2.s_valid = 1'b0;
    end
    #1;
    chk("b2b_end_m_valid", if2.m_valid, 0);
    chk("b2b_end_busy",    if2.busy,    0);

    // N=3 8'h3C with random m_ready (about 1/3 duty)
    @(negedge clk);
    w8 = 8'h3C;
    if3.s_data = w8; if3.s_valid = 1'b1; if3.m_ready = 1'b1;
    @(negedge clk);
    if3.s_valid = 1'b0; if3.s_data = 8'hFF;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      if3.m_ready = ($urandom_range(0, 2) == 0);
      #1;
      e = w8[bidx(idx, 3)];
      chk($sformatf("bp_c%0d_valid", cyc), if3.m_valid, 1);
      chk($sformatf("bp_c%0d_data", cyc),  if3.m_data,  {31'd0, e});
      chk($sformatf("bp_c%0d_last", cyc),  if3.m_last,  (idx == 7) ? 1 : 0);
      chk($sformatf("bp_c%0d_rdy", cyc),   if3.s_ready, (if3.m_ready && idx == 7) ? 1 : 0);
      if (if3.m_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("bp_all_bits_sent", idx, 8);
    if3.m_ready = 1'b1;
    #1;
    chk("bp_end_busy", if3.busy, 0);

    // Reset in the middle of 8'hFF, then a fresh 8'h01
    @(negedge clk);
    w8 = 8'hFF;
    if3.s_data = w8; if3.s_valid = 1'b1;
    @(negedge clk);
    if3.s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ff_b%0d_data", i), if3.m_data, 1);
      @(negedge clk);
    end
    #1;
    chk("ff_pre_rst_valid", if3.m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", if3.m_valid, 0);
    chk("mid_rst_m_last",  if3.m_last,  0);
    chk("mid_rst_busy",    if3.busy,    0);
    chk("mid_rst_s_ready", if3.s_ready, 0);
    chk("mid_rst_m_data",  if3.m_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    w8 = 8'h01;
    if3.s_data = w8; if3.s_valid = 1'b1;
    #1;
    chk("post_rst_s_ready", if3.s_ready, 1);
    @(negedge clk);
    if3.s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = w8[bidx(i, 3)];
      chk($sformatf("p01_b%0d_data", i), if3.m_data, {31'd0, e});
      chk($sformatf("p01_b%0d_last", i), if3.m_last, (i == 7) ? 1 : 0);
      @(negedge clk);
    end
    #1;
    chk("p01_end_busy", if3.busy, 0);

    // N=1, 2'b10
    @(negedge clk);
    w2 = 2'b10;
    if1.s_data = w2; if1.s_valid = 1'b1;
    @(negedge clk);
    if1.s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      e = w2[bidx(i, 1)];
      chk($sformatf("n1_b%0d_valid", i), if1.m_valid, 1);
      chk($sformatf("n1_b%0d_data", i),  if1.m_data,  {31'd0, e});
      chk($sformatf("n1_b%0d_last", i),  if1.m_last,  (i == 1) ? 1 : 0);
      @(negedge clk);
    end
    #1;
    chk("n1_end_m_valid", if1.m_valid, 0);
    chk("n1_end_busy",    if1.busy,    0);
    chk("n1_end_s_ready", if1.s_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
